bcd_tick_counter: RTL and testbench
===================================

# bcd_tick_counter

Multi-digit BCD event counter that consumes the divided-clock output of the frequency-divider stage. The block samples that slow square wave in the fast `iclk` domain, detects its rising edges, and advances a packed BCD count under a run/hold/clear control FSM. The digits feed the display stage downstream, and a wrap pulse is provided for cascading.

## Interface
- `DIGITS`, default 4: number of BCD digits; legal range 1–8.
- `iclk`  in  1  system clock; all state changes on its rising edge.
- `irst`  in  1  reset, synchronous, active-high.
- `itick`  in  1  divided clock from the divider stage, treated as a level.
- `istart`  in  1  request RUN; level, sampled each edge.
- `istop`  in  1  request HOLD; level, sampled each edge.
- `iclear`  in  1  zero the count and return to IDLE.
- `iup`  in  1  direction: 1 = count up, 0 = count down.
- `odigits`  out  4*DIGITS  packed BCD; digit 0 (least significant) in bits [3:0].
- `ocarry`  out  1  one-cycle pulse on wrap, in either direction.
- `orun`  out  1  high while the FSM is in RUN.

## Operation
- FSM states:
  - IDLE: entered from reset or clear.
  - RUN: counting.
  - HOLD: stopped, count retained.
- Transition priority at each edge: `irst` > `iclear` > `istop` > `istart`.
  - `iclear` from any state: go to IDLE and set `odigits` = 0.
  - `istop` from RUN: go to HOLD. In IDLE or HOLD it has no effect.
  - `istart` from IDLE or HOLD: go to RUN. In RUN it has no effect.
- Edge detect: two registers, t0 ← `itick` and t1 ← t0.
  - tick = t0 & ~t1.
  - Reset loads both t0 and t1 to 1, so a high `itick` at reset release is never counted.
- Counting happens only when the current state register is RUN and tick = 1.
  - `iup` is sampled on the same edge as the count.
- Up count: digit 0 increments. A digit at 9 goes to 0 and carries into the next digit.
  - All digits 9 → all digits 0, and `ocarry` = 1 for one cycle.
- Down count: digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit.
  - All digits 0 → all digits 9, and `ocarry` = 1 for one cycle.
- Digits never hold a non-BCD value (A–F) at any time.
- Simultaneous events:
  - tick with `iclear` on the same edge: clear wins and the tick is discarded.
  - tick with `istop` while in RUN: the tick is counted, and the state is HOLD from the next cycle.
  - tick with `istart` while in IDLE or HOLD: the tick is not counted.
- Reset mid-count: the next edge forces `odigits` = 0, `ocarry` = 0, `orun` = 0, and state IDLE, regardless of other inputs.

## Timing
- Reset values: `odigits` = 0, `ocarry` = 0, `orun` = 0, state IDLE, t0 = t1 = 1.
- All outputs are registered; there is no combinational input-to-output path.
- Latency: if `itick` is first sampled high at edge N, `odigits` and `ocarry` update at edge N+1. `ocarry` deasserts at edge N+2.
- `orun` rises on the edge that accepts `istart`. It falls on the edge that accepts `istop` or `iclear`.
- `itick` minimum high and low phase is 1 `iclk` cycle. The maximum count rate is therefore one tick per 2 cycles, which matches a divide-by-2 source.

## Configuration
- Macro: `BCD_TICK_SYNC_EN`.
- When defined:
  - Two extra flops (s0, s1) sit ahead of t0, for an `itick` that is asynchronous to `iclk`.
  - Reset loads s0 and s1 to 1.
  - Latency becomes N+3.
  - Minimum `itick` phase becomes 2 cycles.
- When undefined: `itick` must be synchronous to `iclk`, and latency is N+1.

## Test plan
- Reset then start:
  - Stimulus: hold `irst` for 2 cycles with `itick` high, release, pulse `istart`, then drive `itick` = `iclk`/2 for 8 rising ticks with `iup` = 1.
  - Response: `odigits` = 0x0008, and no count is taken at reset release.
- Up wrap:
  - Stimulus: count up from 0x9998 with 2 ticks.
  - Response: 0x9999, then 0x0000, with `ocarry` high for exactly 1 cycle on the second tick.
- Down wrap:
  - Stimulus: from 0x0001 with `iup` = 0, apply 2 ticks.
  - Response: 0x0000, then 0x9999, with `ocarry` pulsed once.
- Hold and resume:
  - Stimulus: assert `istop` at count 0x0042, apply 5 ticks, pulse `istart`, apply 3 ticks.
  - Response: `odigits` stays 0x0042 and `orun` = 0 while held, then ends at 0x0045.
- Simultaneous events:
  - Stimulus A: `iclear` on the same edge as a tick.
  - Response A: 0x0000, state IDLE.
  - Stimulus B: `istop` on the same edge as a tick at 0x0010.
  - Response B: 0x0011, then HOLD.
- Latency check:
  - Stimulus: sample `itick` high at edge N, with and without `BCD_TICK_SYNC_EN`.
  - Response: `odigits` changes at edge N+1 and N+3 respectively.

Source files
------------

// File: rtl/bcd_tick_counter.sv
// BCD event counter: edge-detects a divided clock and counts under run/hold/clear.
// Define BCD_TICK_SYNC_EN to add a two-flop synchronizer ahead of the edge detector.
module bcd_tick_counter #(
  parameter int DIGITS = 4
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              itick,
  input  logic              istart,
  input  logic              istop,
  input  logic              iclear,
  input  logic              iup,
  output logic [4*DIGITS-1:0] odigits,
  output logic              ocarry,
  output logic              orun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic carry_q, carry_d;
  logic run_q, run_d;
  logic t0_q, t1_q;
  logic tick_src;
  logic tick;

`ifdef BCD_TICK_SYNC_EN
  logic s0_q, s1_q;

  // Two-flop synchronizer for an itick from another clock domain
  always_ff @(posedge iclk) begin
    if (irst) begin
      s0_q <= 1'b1;
      s1_q <= 1'b1;
    end else begin
      s0_q <= itick;
      s1_q <= s0_q;
    end
  end

  assign tick_src = s1_q;
`else
  assign tick_src = itick;
`endif

  // Rising-edge detector; preset high so a high level at reset exit is ignored
  always_ff @(posedge iclk) begin
    if (irst) begin
      t0_q <= 1'b1;
      t1_q <= 1'b1;
    end else begin
      t0_q <= tick_src;
      t1_q <= t0_q;
    end
  end

  assign tick = t0_q & ~t1_q;

  // Next-state, digit arithmetic and registered output values
  always_comb begin
    logic       c;
    logic [3:0] d;
    state_d  = state_q;
    digits_d = digits_q;
    carry_d  = 1'b0;
    c        = 1'b0;
    d        = 4'd0;
    if (iclear) begin
      state_d  = IDLE;
      digits_d = '0;
    end else begin
      if (state_q == RUN && tick) begin
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
          d = digits_q[i*4 +: 4];
          if (c) begin
            if (iup) begin
              if (d >= 4'd9) begin
                d = 4'd0;
              end else begin
                d = d + 4'd1;
                c = 1'b0;
              end
            end else begin
              if (d == 4'd0) begin
                d = 4'd9;
              end else begin
                d = d - 4'd1;
                c = 1'b0;
              end
            end
          end
          digits_d[i*4 +: 4] = d;
        end
        carry_d = c;
      end
      unique case (state_q)
        RUN: begin
          if (istop) state_d = HOLD;
        end
        IDLE, HOLD: begin
          if (!istop && istart) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
    run_d = (state_d == RUN);
  end

  // State and output registers
  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q  <= IDLE;
      digits_q <= '0;
      carry_q  <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      carry_q  <= carry_d;
      run_q    <= run_d;
    end
  end

  assign odigits = digits_q;
  assign ocarry  = carry_q;
  assign orun    = run_q;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Directed bench for bcd_tick_counter; honours BCD_TICK_SYNC_EN for latency.
module tb_bcd_tick_counter;

`ifdef BCD_TICK_SYNC_EN
  localparam int PH  = 2;
  localparam int LAT = 3;
`else
  localparam int PH  = 1;
  localparam int LAT = 1;
`endif

  logic        iclk = 1'b0;
  logic        irst = 1'b1;
  logic        itick = 1'b1;
  logic        istart = 1'b0;
  logic        istop = 1'b0;
  logic        iclear = 1'b0;
  logic        iup = 1'b1;
  logic [15:0] odigits;
  logic        ocarry;
  logic        orun;

  int tests = 0;
  int fails = 0;

  bcd_tick_counter #(.DIGITS(4)) dut (
    .iclk(iclk), .irst(irst), .itick(itick),
    .istart(istart), .istop(istop), .iclear(iclear),
    .iup(iup), .odigits(odigits), .ocarry(ocarry), .orun(orun)
  );

  always #5 iclk = ~iclk;

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full itick period; the count lands on the last edge
  task automatic tick1();
    itick = 1'b1;
    repeat (PH) step();
    itick = 1'b0;
    repeat (PH) step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick1();
  endtask

  // Leaves the bench just before the edge on which a tick is counted
  task automatic pre_tick();
    itick = 1'b1;
    repeat (PH) step();
    itick = 1'b0;
    repeat (LAT - PH) step();
  endtask

  task automatic pulse_start();
    istart = 1'b1; step(); istart = 1'b0;
  endtask

  task automatic pulse_clear();
    iclear = 1'b1; step(); iclear = 1'b0;
  endtask

  initial begin
    // Reset with itick held high
    irst = 1'b1; itick = 1'b1;
    repeat (2) step();
    irst = 1'b0;
    check("rst_digits", odigits, 16'h0000);
    check("rst_carry", ocarry, 1'b0);
    check("rst_run", orun, 1'b0);
    repeat (4) step();
    pulse_start();
    check("start_run", orun, 1'b1);
    repeat (4) step();
    check("no_tick_at_release", odigits, 16'h0000);
    itick = 1'b0;
    repeat (4) step();
    ticks(8);
    check("up8", odigits, 16'h0008);

    // Reach 9998 by counting down from zero, then wrap upward
    pulse_clear();
    check("clr_run", orun, 1'b0);
    check("clr_digits", odigits, 16'h0000);
    pulse_start();
    iup = 1'b0;
    tick1();
    check("down_wrap_val", odigits, 16'h9999);
    check("down_wrap_carry", ocarry, 1'b1);
    step();
    check("down_wrap_carry_off", ocarry, 1'b0);
    tick1();
    check("down_9998", odigits, 16'h9998);
    check("no_carry_9998", ocarry, 1'b0);
    iup = 1'b1;
    tick1();
    check("up_9999", odigits, 16'h9999);
    check("up_9999_carry", ocarry, 1'b0);
    tick1();
    check("up_wrap_val", odigits, 16'h0000);
    check("up_wrap_carry", ocarry, 1'b1);
    step();
    check("up_wrap_carry_off", ocarry, 1'b0);

    // Down wrap from 0001
    tick1();
    check("up_0001", odigits, 16'h0001);
    iup = 1'b0;
    tick1();
    check("down_0000", odigits, 16'h0000);
    check("down_0000_carry", ocarry, 1'b0);
    tick1();
    check("down_wrap2", odigits, 16'h9999);
    check("down_wrap2_carry", ocarry, 1'b1);
    step();
    check("down_wrap2_off", ocarry, 1'b0);
    iup = 1'b1;

    // Hold and resume at 0042
    pulse_clear();
    pulse_start();
    ticks(42);
    check("pre_hold", odigits, 16'h0042);
    istop = 1'b1; step(); istop = 1'b0;
    check("hold_run", orun, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick1();
      check("held_digits", odigits, 16'h0042);
      check("held_run", orun, 1'b0);
    end
    pulse_start();
    check("resume_run", orun, 1'b1);
    ticks(3);
    check("resumed", odigits, 16'h0045);

    // Clear on the counting edge
    pre_tick();
    iclear = 1'b1; step(); iclear = 1'b0;
    check("clr_tick_digits", odigits, 16'h0000);
    check("clr_tick_run", orun, 1'b0);
    tick1();
    check("idle_no_count", odigits, 16'h0000);

    // Stop on the counting edge at 0010
    pulse_start();
    ticks(10);
    check("at_0010", odigits, 16'h0010);
    pre_tick();
    istop = 1'b1; step(); istop = 1'b0;
    check("stop_tick_digits", odigits, 16'h0011);
    check("stop_tick_run", orun, 1'b0);
    tick1();
    check("stop_then_hold", odigits, 16'h0011);

    // Start on a tick edge from HOLD: tick discarded
    pre_tick();
    istart = 1'b1; step(); istart = 1'b0;
    check("start_tick_digits", odigits, 16'h0011);
    check("start_tick_run", orun, 1'b1);

    // Latency from first high sample
    itick = 1'b1;
    step();
    for (int k = 1; k < LAT; k++) begin
      if (k >= PH) itick = 1'b0;
      check("lat_unchanged", odigits, 16'h0011);
      step();
    end
    check("lat_before", odigits, 16'h0011);
    itick = 1'b0;
    step();
    check("lat_after", odigits, 16'h0012);
    repeat (4) step();

    // Reset mid-count with other inputs active
    istart = 1'b1; iclear = 1'b0; itick = 1'b1; irst = 1'b1;
    step();
    check("mid_rst_digits", odigits, 16'h0000);
    check("mid_rst_carry", ocarry, 1'b0);
    check("mid_rst_run", orun, 1'b0);
    irst = 1'b0; istart = 1'b0;
    step();
    check("post_rst_idle_run", orun, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
